sign_narrow: RTL and testbench
==============================

# sign_narrow

Registered narrowing stage for signed values, the inverse of the `sign_extend` block. It accepts a WIDE_WIDTH two's-complement word and emits a NARROW_WIDTH word, either saturated or wrapped. Every result whose value did not fit is flagged, and a sticky flag and counter record overflows. It sits on the store/immediate-encode datapath, between the execute result and any 12-bit field consumer, behind a valid/ready handshake with a 2-entry skid buffer.

## Interface
- WIDE_WIDTH, 32, input word width.
- NARROW_WIDTH, 12, output word width; must be >= 2 and < WIDE_WIDTH.
- CNT_WIDTH, 16, overflow counter width.

- clk  in  1  single clock; all state is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept; registered.
- in_data  in  WIDE_WIDTH  signed input.
- in_sat  in  1  sampled with in_data: 1 = saturate, 0 = wrap.
- out_valid  out  1  output word present.
- out_ready  in  1  downstream accepts.
- out_data  out  NARROW_WIDTH  narrowed result.
- out_ovf  out  1  this result did not fit in NARROW_WIDTH signed.
- clr  in  1  synchronous clear of ovf_sticky and ovf_count.
- ovf_sticky  out  1  set by any accepted overflowing word.
- ovf_count  out  CNT_WIDTH  accepted overflowing words; saturates at all-ones.

## Operation
- **Accept:** a word is accepted in a cycle where in_valid && in_ready. The result is computed combinationally from in_data and in_sat, then stored.
- **Fit test:** the word fits when in_data[WIDE_WIDTH-1:NARROW_WIDTH-1] is all-zeros or all-ones. ovf = !fit.
- **Result when it fits:** in_data[NARROW_WIDTH-1:0].
- **Result on overflow with in_sat=1:**
  - in_data MSB = 0: 0 followed by all-ones, i.e. 2^(N-1)-1 (0x7FF).
  - in_data MSB = 1: 1 followed by all-zeros, i.e. -2^(N-1) (0x800).
- **Result on overflow with in_sat=0:** in_data[NARROW_WIDTH-1:0], with out_ovf=1.
- **Storage:** two entries, main (drives outputs) and skid. Each entry holds {data, ovf, valid}.
  - Main loads the accepted word when main is empty or being consumed (out_ready) and skid is empty.
  - Otherwise the accepted word goes to skid.
  - When main is consumed and skid is valid, skid moves to main; a new accept in the same cycle goes to skid.
- **in_ready** = !skid.valid, registered.
- **ovf_count / ovf_sticky:** updated on accept (not on output).
  - Accepted ovf: count +1, saturating at 2^CNT_WIDTH-1; sticky set.
  - clr alone: count = 0, sticky = 0.
  - clr plus an accepted ovf word in the same cycle: count = 1, sticky = 1.

## Timing
- Reset values: in_ready=1 (the skid entry is empty at reset), out_valid=0, out_data=0, out_ovf=0, ovf_sticky=0, ovf_count=0. Both entries are empty.
- Latency: accept at edge k gives out_valid=1 after edge k, i.e. 1 cycle, when main is empty.
- Throughput: one word per cycle while out_ready=1.
- Backpressure:
  - With out_ready=0, at most 2 words are held.
  - in_ready falls the cycle after the second is accepted.
  - No word is dropped or duplicated.
- Stability: out_data and out_ovf are stable while out_valid && !out_ready.
- in_ready does not depend combinationally on out_ready.
- Reset mid-transfer: asserting rst asynchronously discards both entries and all counters; outputs return to reset values immediately.
- Counter at all-ones plus another overflow: it holds all-ones and the sticky flag stays 1.

## Structure
- Shared package sign_pkg holds:
  - the entry struct {data, ovf, valid};
  - localparam helpers for the saturation constants SAT_POS and SAT_NEG, expressed as functions of NARROW_WIDTH.
- Sub-module sign_narrow_calc: purely combinational fit test plus sat/wrap select. sign_narrow instantiates it and owns the skid buffer and counters.

## Test plan
- **In range:** in_data=0x000002AA and 0xFFFFF87F, either in_sat → out_data=0x2AA and 0x87F respectively, out_ovf=0, count unchanged, each 1 cycle after accept.
- **Overflow:** in_data=0x00000800 with in_sat=1 → 0x7FF ovf=1; with in_sat=0 → 0x800 ovf=1. in_data=0x80000000 with in_sat=1 → 0x800 ovf=1. Afterwards ovf_count=3 and ovf_sticky=1.
- **Backpressure:**
  - Hold out_ready=0 and offer 0x001, 0x002, 0x003 back-to-back → in_ready=0 after two accepts.
  - Release out_ready → the outputs appear in order 0x001, 0x002, then 0x003; none lost.
  - out_data is stable while stalled.
- **Counter saturation and clear:**
  - With CNT_WIDTH=2, 5 overflowing words → count=3.
  - clr alone → count 0, sticky 0.
  - clr in the same cycle as an overflowing accept → count=1, sticky=1.
- **Reset mid-operation:** with both entries full, pulse rst between edges → out_valid=0, in_ready=1, count=0 before the next edge. The next accepted 0x005 appears alone.
- **Streaming:** 100 random words with random out_ready stalls → output sequence matches a reference model exactly, and the counter equals the model's overflow total.

Source files
------------

// File: rtl/sign_pkg.sv
// sign_pkg: shared entry type and saturation constants for the narrowing stage.
package sign_pkg;
  localparam int NARROW_W = 12;
  localparam logic [NARROW_W-1:0] SAT_POS = {1'b0, {(NARROW_W-1){1'b1}}};
  localparam logic [NARROW_W-1:0] SAT_NEG = {1'b1, {(NARROW_W-1){1'b0}}};
  typedef struct packed {
    logic [NARROW_W-1:0] data;
    logic                ovf;
    logic                valid;
  } entry_t;
endpackage

// File: rtl/sign_narrow_calc.sv
// sign_narrow_calc: combinational fit test and saturate/wrap select.
module sign_narrow_calc
  import sign_pkg::*;
#(
  parameter int WIDE_WIDTH   = 32,
  parameter int NARROW_WIDTH = NARROW_W
) (
  input  logic [WIDE_WIDTH-1:0]   in_data,
  input  logic                    in_sat,
  output logic [NARROW_WIDTH-1:0] res,
  output logic                    ovf
);
  logic [WIDE_WIDTH-NARROW_WIDTH:0] top;
  assign top = in_data[WIDE_WIDTH-1:NARROW_WIDTH-1];
  assign ovf = !((&top) || !(|top));
  assign res = (ovf && in_sat) ? (in_data[WIDE_WIDTH-1] ? SAT_NEG : SAT_POS)
                               : in_data[NARROW_WIDTH-1:0];
endmodule

// File: rtl/sign_narrow.sv
// sign_narrow: registered signed narrowing with 2-entry skid buffer and overflow tracking.
module sign_narrow
  import sign_pkg::*;
#(
  parameter int WIDE_WIDTH   = 32,
  parameter int NARROW_WIDTH = NARROW_W,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDE_WIDTH-1:0]   in_data,
  input  logic                    in_sat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NARROW_WIDTH-1:0] out_data,
  output logic                    out_ovf,
  input  logic                    clr,
  output logic                    ovf_sticky,
  output logic [CNT_WIDTH-1:0]    ovf_count
);
  logic [NARROW_WIDTH-1:0] res;
  logic ovf, accept, advance, acc_ovf, sticky_n;
  logic [CNT_WIDTH-1:0] cnt_n;
  entry_t main_q, skid_q, main_n, skid_n, new_e;
  sign_narrow_calc #(.WIDE_WIDTH(WIDE_WIDTH), .NARROW_WIDTH(NARROW_WIDTH)) u_calc (
    .in_data(in_data),
    .in_sat (in_sat),
    .res    (res),
    .ovf    (ovf)
  );
  assign in_ready   = !skid_q.valid;
  assign accept     = in_valid && in_ready;
  assign advance    = !main_q.valid || out_ready;
  assign acc_ovf    = accept && ovf;
  assign out_valid  = main_q.valid;
  assign out_data   = main_q.data;
  assign out_ovf    = main_q.ovf;
  // skid always drains into main first so ordering is preserved
  always_comb begin
    new_e    = '{data: res, ovf: ovf, valid: accept};
    main_n   = advance ? (skid_q.valid ? skid_q : new_e) : main_q;
    skid_n   = advance ? (skid_q.valid ? new_e : '0) : (accept ? new_e : skid_q);
    cnt_n    = clr ? CNT_WIDTH'(acc_ovf) : ovf_count + CNT_WIDTH'(acc_ovf && !(&ovf_count));
    sticky_n = (ovf_sticky && !clr) || acc_ovf;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      ovf_count  <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      main_q     <= main_n;
      skid_q     <= skid_n;
      ovf_count  <= cnt_n;
      ovf_sticky <= sticky_n;
    end
endmodule

// File: tb/tb_sign_narrow.sv
// tb_sign_narrow: scoreboard bench for sign_narrow (CNT_WIDTH=2 to reach saturation quickly).
module tb_sign_narrow;
  logic        clk = 0, rst = 1, in_valid = 0, in_sat = 0, out_ready = 1, clr = 0;
  logic [31:0] in_data = 0;
  logic        in_ready, out_valid, out_ovf, ovf_sticky;
  logic [11:0] out_data;
  logic [1:0]  ovf_count;
  logic [12:0] exp_q[$];
  logic [12:0] cur_exp, got;
  logic        rand_rdy = 0;
  int          n_cmp = 0, n_bad = 0, model_cnt = 0;

  sign_narrow #(.WIDE_WIDTH(32), .NARROW_WIDTH(12), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sat(in_sat), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .clr(clr), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] model(input logic [31:0] d, input logic s);
    logic [20:0] t;
    logic o;
    t = d[31:11];
    o = !(t == 21'h0 || t == 21'h1FFFFF);
    return {o, (o && s) ? (d[31] ? 12'h800 : 12'h7FF) : d[11:0]};
  endfunction

  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", {19'b0, out_ovf, out_data}, 32'h1FFFF);
      else begin
        got = exp_q.pop_front();
        chk("sb_data", {20'b0, out_data}, {20'b0, got[11:0]});
        chk("sb_ovf", {31'b0, out_ovf}, {31'b0, got[12]});
      end
    end

  always @(posedge clk)
    if (rand_rdy) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end

  task automatic send(input logic [31:0] d, input logic s, input logic [11:0] ed, input logic eo);
    bit done = 0;
    in_valid = 1; in_data = d; in_sat = s;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({eo, ed});
        if (eo) model_cnt = (model_cnt == 3) ? 3 : model_cnt + 1;
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (exp_q.size() == 0 && !out_valid) done = 1;
      else begin @(posedge clk); #1; end
    end
    if (!done) chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_out_data", {20'b0, out_data}, 0);
    chk("rst_out_ovf", {31'b0, out_ovf}, 0);
    chk("rst_sticky", {31'b0, ovf_sticky}, 0);
    chk("rst_count", {30'b0, ovf_count}, 0);
    rst = 0;
    @(posedge clk); #1;
    // in range, both saturation modes
    send(32'h000002AA, 1, 12'h2AA, 0);
    chk("lat_valid", {31'b0, out_valid}, 1);
    chk("lat_data", {20'b0, out_data}, 32'h2AA);
    send(32'hFFFFF87F, 0, 12'h87F, 0);
    chk("lat_data2", {20'b0, out_data}, 32'h87F);
    send(32'h000002AA, 0, 12'h2AA, 0);
    send(32'hFFFFF87F, 1, 12'h87F, 0);
    drain();
    chk("inrange_count", {30'b0, ovf_count}, 0);
    chk("inrange_sticky", {31'b0, ovf_sticky}, 0);
    // overflow
    send(32'h00000800, 1, 12'h7FF, 1);
    send(32'h00000800, 0, 12'h800, 1);
    send(32'h80000000, 1, 12'h800, 1);
    drain();
    chk("ovf_count3", {30'b0, ovf_count}, 3);
    chk("ovf_sticky", {31'b0, ovf_sticky}, 1);
    send(32'h7FFFFFFF, 1, 12'h7FF, 1);
    send(32'hFFFFF7FF, 1, 12'h800, 1);
    drain();
    chk("cnt_saturated", {30'b0, ovf_count}, 3);
    chk("sticky_held", {31'b0, ovf_sticky}, 1);
    clr = 1; @(posedge clk); #1; clr = 0;
    chk("clr_count", {30'b0, ovf_count}, 0);
    chk("clr_sticky", {31'b0, ovf_sticky}, 0);
    clr = 1;
    send(32'h00001000, 0, 12'h000, 1);
    clr = 0;
    chk("clr_ovf_count", {30'b0, ovf_count}, 1);
    chk("clr_ovf_sticky", {31'b0, ovf_sticky}, 1);
    drain();
    // backpressure
    out_ready = 0;
    send(32'h1, 0, 12'h001, 0);
    chk("bp_ready1", {31'b0, in_ready}, 1);
    send(32'h2, 0, 12'h002, 0);
    chk("bp_ready0", {31'b0, in_ready}, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_stable", {20'b0, out_data}, 32'h001);
    chk("bp_still_full", {31'b0, in_ready}, 0);
    out_ready = 1;
    send(32'h3, 0, 12'h003, 0);
    drain();
    // reset with both entries full
    out_ready = 0;
    send(32'h100, 0, 12'h100, 0);
    send(32'h101, 0, 12'h101, 0);
    rst = 1; #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 0);
    chk("mid_rst_ready", {31'b0, in_ready}, 1);
    chk("mid_rst_count", {30'b0, ovf_count}, 0);
    chk("mid_rst_data", {20'b0, out_data}, 0);
    rst = 0;
    exp_q.delete();
    model_cnt = 0;
    out_ready = 1;
    send(32'h5, 0, 12'h005, 0);
    drain();
    repeat (4) begin @(posedge clk); #1; end
    // random streaming
    clr = 1; @(posedge clk); #1; clr = 0;
    model_cnt = 0;
    rand_rdy = 1;
    for (int i = 0; i < 100; i++) begin
      logic [31:0] d;
      logic s;
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d = {{20{d[12]}}, d[11:0]};
      s = 1'($urandom_range(0, 1));
      cur_exp = model(d, s);
      send(d, s, cur_exp[11:0], cur_exp[12]);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    rand_rdy = 0;
    #2 out_ready = 1;
    drain();
    chk("stream_count", {30'b0, ovf_count}, model_cnt);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
